// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks: active-low glyphs,
// blank patterns and the counter width helper.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic {
        PH_DEAD,
        PH_LIT
    } slot_phase_e;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit to 7-segment decoder, active-low, bit order g..a.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_0;
        case (hex_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            default: seg_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered frame loads.
// Define SEG_LZ_BLANK_EN to enable leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int DEAD_CYC = 50
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [DIGITS-1:0]     seg_sel,
    output logic [7:0]            seg_led,
    output logic                  frame_start,
    output logic                  upd_done
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CW    = cnt_width(DWELL);
    localparam int IW    = cnt_width(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  pend_bcd_q, pend_bcd_d, shadow_bcd_q, shadow_bcd_d;
    logic [DIGITS-1:0]    pend_dp_q, pend_dp_d, shadow_dp_q, shadow_dp_d;
    logic                 pend_v_q, pend_v_d, shadow_upd_q, shadow_upd_d;
    logic [DIGITS-1:0]    seg_sel_q, seg_sel_d;
    logic [7:0]           seg_led_q, seg_led_d;
    logic                 frame_start_q, upd_done_q;

    logic                 wrap, boundary;
    logic [DIGITS-1:0]    blank_mask;
    logic [3:0]           cur_nib;
    logic                 cur_dp, cur_blank;
    logic [6:0]           cur_glyph;
    slot_phase_e          phase;

    assign wrap     = (cnt_q == CNT_LAST);
    assign boundary = wrap && (idx_q == IDX_LAST);

    // Boundary transfers bypass the pending buffer when a load coincides with it.
    always_comb begin
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_v_d     = pend_v_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_upd_d = 1'b0;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (boundary) begin
            if (load) begin
                shadow_bcd_d = bcd_in;
                shadow_dp_d  = dp_in;
                shadow_upd_d = 1'b1;
            end else if (pend_v_q) begin
                shadow_bcd_d = pend_bcd_q;
                shadow_dp_d  = pend_dp_q;
                shadow_upd_d = 1'b1;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_bcd_d = bcd_in;
            pend_dp_d  = dp_in;
            pend_v_d   = 1'b1;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic nz_above;

    // A digit is blank while nothing at or above it is non-zero or has its dp set.
    always_comb begin
        blank_mask = '0;
        nz_above   = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nz_above      = nz_above | (shadow_bcd_q[4*k +: 4] != 4'h0) | shadow_dp_q[k];
            blank_mask[k] = ~nz_above;
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(idx_q) == k) begin
                cur_nib   = shadow_bcd_q[4*k +: 4];
                cur_dp    = shadow_dp_q[k];
                cur_blank = blank_mask[k];
            end
        end
    end

    seg_hex_decode u_dec (
        .hex_i (cur_nib),
        .seg_o (cur_glyph)
    );

    always_comb begin
        phase     = (cnt_q < DEAD_LIM) ? PH_DEAD : PH_LIT;
        seg_sel_d = SEL_OFF[DIGITS-1:0];
        seg_led_d = SEG_OFF;
        if (phase == PH_LIT && !cur_blank) begin
            seg_sel_d = ~(DIGITS'(1) << idx_q);
            seg_led_d = {~cur_dp, cur_glyph};
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_bcd_q    <= '0;
            pend_dp_q     <= '0;
            pend_v_q      <= 1'b0;
            shadow_bcd_q  <= '0;
            shadow_dp_q   <= '0;
            shadow_upd_q  <= 1'b0;
            seg_sel_q     <= SEL_OFF[DIGITS-1:0];
            seg_led_q     <= SEG_OFF;
            frame_start_q <= 1'b0;
            upd_done_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pend_bcd_q    <= pend_bcd_d;
            pend_dp_q     <= pend_dp_d;
            pend_v_q      <= pend_v_d;
            shadow_bcd_q  <= shadow_bcd_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_upd_q  <= shadow_upd_d;
            seg_sel_q     <= seg_sel_d;
            seg_led_q     <= seg_led_d;
            frame_start_q <= (cnt_q == '0) && (idx_q == '0);
            upd_done_q    <= shadow_upd_q;
        end
    end

    assign seg_sel     = seg_sel_q;
    assign seg_led     = seg_led_q;
    assign frame_start = frame_start_q;
    assign upd_done    = upd_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues expected frame/slot
// events, a monitor reconstructs events from the pins and compares them.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b0;
    logic        load    = 1'b0;
    logic [15:0] bcd_in  = 16'h0;
    logic [3:0]  dp_in   = 4'h0;
    logic [3:0]  seg_sel;
    logic [7:0]  seg_led;
    logic        frame_start;
    logic        upd_done;

    typedef struct packed {
        logic       kind;
        logic [3:0] sel;
        logic [7:0] led;
        logic [7:0] off;
        logic [7:0] len;
        logic       upd;
        logic [7:0] period;
    } evt_t;

    evt_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   t           = 0;
    bit   monEnable   = 1'b0;

    logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .CLK_HZ   (1000),
        .SCAN_HZ  (100),
        .DEAD_CYC (2)
    ) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .load        (load),
        .seg_sel     (seg_sel),
        .seg_led     (seg_led),
        .frame_start (frame_start),
        .upd_done    (upd_done)
    );

    always #5 clk_50M = ~clk_50M;

    // Queue one frame: the frame_start event, then each visible digit slot.
    task automatic pushFrame(input logic [15:0] bcd, input logic [3:0] dp,
                             input logic upd, input int per, input bit frameOnly);
        evt_t       e;
        logic [3:0] blank;
        logic       nzAbove;
        logic [3:0] nib;
        e        = '0;
        e.upd    = upd;
        e.period = 8'(per);
        expQ.push_back(e);
        blank   = 4'h0;
        nzAbove = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        for (int k = 3; k >= 1; k--) begin
            nzAbove  = nzAbove | (bcd[4*k +: 4] != 4'h0) | dp[k];
            blank[k] = ~nzAbove;
        end
`endif
        if (!frameOnly) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (!blank[d]) begin
                    nib    = bcd[4*d +: 4];
                    e      = '0;
                    e.kind = 1'b1;
                    e.sel  = ~(4'b0001 << d);
                    e.led  = {~dp[d], glyphTab[nib]};
                    e.off  = 8'(10*d + 2);
                    e.len  = 8'd8;
                    expQ.push_back(e);
                end
            end
        end
    endtask

    task automatic compareEvt(input evt_t act);
        evt_t ex;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_event: got kind=%0d sel=%b led=%h off=%0d len=%0d upd=%b period=%0d, required no event",
                     act.kind, act.sel, act.led, act.off, act.len, act.upd, act.period);
        end else begin
            ex = expQ.pop_front();
            if (act !== ex) begin
                miscompares++;
                $display("[TB] FAIL %s_event: got sel=%b led=%h off=%0d len=%0d upd=%b period=%0d, required sel=%b led=%h off=%0d len=%0d upd=%b period=%0d",
                         ex.kind ? "slot" : "frame",
                         act.sel, act.led, act.off, act.len, act.upd, act.period,
                         ex.sel, ex.led, ex.off, ex.len, ex.upd, ex.period);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expSel,
                               input logic [7:0] expLed, input logic expFs, input logic expUd);
        vectors++;
        if (seg_sel !== expSel || seg_led !== expLed || frame_start !== expFs || upd_done !== expUd) begin
            miscompares++;
            $display("[TB] FAIL %s: got sel=%b led=%h fs=%b upd=%b, required sel=%b led=%h fs=%b upd=%b",
                     name, seg_sel, seg_led, frame_start, upd_done, expSel, expLed, expFs, expUd);
        end
    endtask

    task automatic waitT(input int target);
        while (t < target) begin
            @(negedge clk_50M);
            t++;
        end
    endtask

    task automatic applyStimulus(input int at, input logic [15:0] bcd, input logic [3:0] dp);
        waitT(at);
        bcd_in = bcd;
        dp_in  = dp;
        load   = 1'b1;
        @(negedge clk_50M);
        t++;
        load = 1'b0;
    endtask

    // Monitor: rebuilds frame and lit-slot events from the pins.
    initial begin
        int         cyc;
        int         frameCyc;
        int         runStart;
        int         runLen;
        bit         haveFrame;
        bit         inRun;
        logic [3:0] runSel;
        logic [7:0] runLed;
        logic [7:0] runOff;
        evt_t       a;
        cyc = 0; frameCyc = 0; runStart = 0; runLen = 0;
        haveFrame = 1'b0; inRun = 1'b0; runSel = 4'hF; runLed = 8'hFF; runOff = 8'h0;
        forever begin
            @(posedge clk_50M);
            #1;
            cyc++;
            if (!monEnable) begin
                inRun     = 1'b0;
                haveFrame = 1'b0;
                continue;
            end
            if (inRun && (seg_sel !== runSel || seg_led !== runLed)) begin
                a      = '0;
                a.kind = 1'b1;
                a.sel  = runSel;
                a.led  = runLed;
                a.off  = runOff;
                a.len  = 8'(runLen);
                compareEvt(a);
                inRun = 1'b0;
            end else if (inRun) begin
                runLen++;
            end
            if (!inRun && seg_sel !== 4'hF) begin
                inRun    = 1'b1;
                runSel   = seg_sel;
                runLed   = seg_led;
                runStart = cyc;
                runLen   = 1;
                runOff   = haveFrame ? 8'(runStart - frameCyc) : 8'hFF;
            end
            if (frame_start === 1'b1) begin
                a        = '0;
                a.upd    = upd_done;
                a.period = haveFrame ? 8'(cyc - frameCyc) : 8'h0;
                compareEvt(a);
                frameCyc  = cyc;
                haveFrame = 1'b1;
            end else if (upd_done !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL upd_alone: got upd_done=%b with frame_start=%b, required upd_done=0", upd_done, frame_start);
            end
            if (seg_sel === 4'hF && seg_led !== 8'hFF) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL idle_segments: got led=%h with sel=%b, required FF", seg_led, seg_sel);
            end
        end
    end

    initial begin
        int guard;
        monEnable = 1'b1;
        repeat (3) @(negedge clk_50M);
        checkOutput("reset_state", 4'hF, 8'hFF, 1'b0, 1'b0);

        pushFrame(16'h0000, 4'h0, 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        t     = 0;
        checkOutput("first_cycle_after_reset", 4'hF, 8'hFF, 1'b0, 1'b0);

        pushFrame(16'h12AF, 4'b0100, 1'b1, 40, 1'b0);
        applyStimulus(15, 16'h12AF, 4'b0100);

        pushFrame(16'h12AF, 4'b0100, 1'b0, 40, 1'b0);
        pushFrame(16'h2222, 4'b0000, 1'b1, 40, 1'b0);
        applyStimulus(85, 16'h1111, 4'b0000);
        applyStimulus(100, 16'h2222, 4'b0000);

        pushFrame(16'h3C5D, 4'b0000, 1'b1, 40, 1'b0);
        pushFrame(16'h3C5D, 4'b0000, 1'b0, 40, 1'b0);
        applyStimulus(130, 16'h9999, 4'b0000);
        applyStimulus(159, 16'h3C5D, 4'b0000);

        pushFrame(16'h0050, 4'b0000, 1'b1, 40, 1'b0);
        applyStimulus(210, 16'h0050, 4'b0000);

        pushFrame(16'h0050, 4'b1000, 1'b1, 40, 1'b0);
        pushFrame(16'h0050, 4'b1000, 1'b0, 40, 1'b1);
        applyStimulus(250, 16'h0050, 4'b1000);

        waitT(321);
        monEnable = 1'b0;
        applyStimulus(330, 16'hAAAA, 4'hF);
        waitT(340);
        rst_n = 1'b0;
        @(negedge clk_50M);
        t++;
        checkOutput("mid_frame_reset", 4'hF, 8'hFF, 1'b0, 1'b0);

        pushFrame(16'h0000, 4'h0, 1'b0, 0, 1'b0);
        pushFrame(16'h0000, 4'h0, 1'b0, 40, 1'b0);
        pushFrame(16'h0000, 4'h0, 1'b0, 40, 1'b1);
        monEnable = 1'b1;
        rst_n     = 1'b1;
        t         = 0;

        guard = 0;
        while (expQ.size() != 0 && guard < 200) begin
            @(negedge clk_50M);
            guard++;
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d expected events outstanding, required 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
